excitation_state_register: RTL and testbench

//   N-bit state register driven by flip-flop excitation signals (D, SR, JK or T).

---
 rtl/ff_pkg.sv | 11 +
 rtl/ff_cell.sv | 58 +++++
 rtl/excitation_state_register.sv | 97 +++++++++
 tb/tb_excitation_state_register.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode encodings and limits for the excitation state register
package ff_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_SR = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [7:0] TRANS_MAX = 8'd255;

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - single-bit flip-flop driven by D, SR, JK or T excitation
module ff_cell
  import ff_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rst_val,
  input  logic       en,
  input  logic       load,
  input  logic       load_val,
  input  logic [1:0] mode,
  input  logic       d,
  input  logic       s,
  input  logic       r,
  input  logic       t,
  output logic       q,
  output logic       q_next,
  output logic       illegal
);

  logic q_q, q_d;

  always_comb begin
    q_d     = q_q;
    illegal = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      case (mode)
        MODE_D:  q_d = d;
        MODE_SR: begin
          // S=R=1 holds the bit and is reported upward as illegal
          if (s && r)  illegal = 1'b1;
          else if (s)  q_d = 1'b1;
          else if (r)  q_d = 1'b0;
        end
        MODE_JK: begin
          case ({s, r})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: if (t) q_d = ~q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/excitation_state_register.sv
// rtl/excitation_state_register.sv - N-bit excitation-driven state register with
// illegal-SR flags, transition counter and state history
module excitation_state_register
  import ff_pkg::*;
#(
  parameter int                N           = 4,
  parameter logic [N-1:0]      RESET_STATE = '0,
  parameter int                HIST_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [N-1:0]            d,
  input  logic [N-1:0]            s,
  input  logic [N-1:0]            r,
  input  logic [N-1:0]            t,
  input  logic                    load,
  input  logic [N-1:0]            load_val,
  input  logic                    clr_illegal,
  output logic [N-1:0]            q,
  output logic [N-1:0]            q_n,
  output logic [N-1:0]            illegal_mask,
  output logic                    changed,
  output logic [7:0]              trans_count,
  output logic [N*HIST_DEPTH-1:0] hist
);

  localparam int HW = N * HIST_DEPTH;

  logic [N-1:0] q_vec, next_q, illegal_vec;
  logic [N-1:0] mask_q, mask_d;
  logic         changed_q;
  logic [7:0]   count_q, count_d;
  logic [HW-1:0] hist_q, hist_d, hist_shift;
  logic         diff;

  for (genvar i = 0; i < N; i++) begin : g_cell
    ff_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .rst_val  (RESET_STATE[i]),
      .en       (en),
      .load     (load),
      .load_val (load_val[i]),
      .mode     (mode),
      .d        (d[i]),
      .s        (s[i]),
      .r        (r[i]),
      .t        (t[i]),
      .q        (q_vec[i]),
      .q_next   (next_q[i]),
      .illegal  (illegal_vec[i])
    );
  end

  if (HIST_DEPTH > 1) begin : g_hist_multi
    assign hist_shift = {hist_q[HW-N-1:0], q_vec};
  end else begin : g_hist_single
    assign hist_shift = q_vec;
  end

  assign diff = (next_q != q_vec);

  always_comb begin
    // A fresh illegal set beats a simultaneous clear for that bit
    mask_d  = (clr_illegal ? '0 : mask_q) | illegal_vec;
    count_d = count_q;
    hist_d  = hist_q;
    if (diff) begin
      hist_d = hist_shift;
      if (count_q != TRANS_MAX) count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      changed_q <= 1'b0;
      count_q   <= '0;
      hist_q    <= '0;
    end else begin
      mask_q    <= mask_d;
      changed_q <= diff;
      count_q   <= count_d;
      hist_q    <= hist_d;
    end
  end

  assign q            = q_vec;
  assign q_n          = ~q_vec;
  assign illegal_mask = mask_q;
  assign changed      = changed_q;
  assign trans_count  = count_q;
  assign hist         = hist_q;

endmodule

// File: tb/tb_excitation_state_register.sv
// tb/tb_excitation_state_register.sv - directed self-checking bench for excitation_state_register
module tb_excitation_state_register;

  logic        clk = 1'b0;
  logic        rst_n, en, load, clr_illegal;
  logic [1:0]  mode;
  logic [3:0]  d, s, r, t, load_val;
  logic [3:0]  q, q_n, illegal_mask;
  logic        changed;
  logic [7:0]  trans_count;
  logic [15:0] hist;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  excitation_state_register dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .s(s), .r(r), .t(t),
    .load(load), .load_val(load_val), .clr_illegal(clr_illegal),
    .q(q), .q_n(q_n), .illegal_mask(illegal_mask), .changed(changed),
    .trans_count(trans_count), .hist(hist)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; clr_illegal = 1'b0;
    mode = 2'b00; d = '0; s = '0; r = '0; t = '0; load_val = '0;
    #12;
    chk("rst_q", q, 4'h0);
    chk("rst_mask", illegal_mask, 4'h0);
    rst_n = 1'b1;
    tick();

    // load 1010, then reset asynchronously mid-cycle
    load = 1'b1; load_val = 4'b1010;
    tick();
    load = 1'b0;
    chk("pre_rst_q", q, 4'b1010);
    chk("pre_rst_cnt", trans_count, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q", q, 4'b0000);
    chk("async_qn", q_n, 4'b1111);
    chk("async_cnt", trans_count, 8'd0);
    chk("async_hist", hist, 16'h0000);
    chk("async_changed", changed, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();

    // D mode
    en = 1'b1; mode = 2'b00; d = 4'b0101;
    tick();
    chk("d_q", q, 4'b0101);
    chk("d_changed", changed, 1'b1);
    chk("d_cnt", trans_count, 8'd1);
    chk("d_hist0", hist[3:0], 4'b0000);
    tick();
    chk("d_same_changed", changed, 1'b0);
    chk("d_same_cnt", trans_count, 8'd1);

    // SR mode
    mode = 2'b01; s = 4'b1000; r = 4'b0001;
    tick();
    chk("sr_q", q, 4'b1100);
    chk("sr_cnt", trans_count, 8'd2);
    s = 4'b0010; r = 4'b0010;
    tick();
    chk("sr_ill_q", q, 4'b1100);
    chk("sr_ill_mask", illegal_mask, 4'b0010);
    chk("sr_ill_changed", changed, 1'b0);
    s = 4'b0000; r = 4'b0000; clr_illegal = 1'b1;
    tick();
    chk("clr_mask", illegal_mask, 4'b0000);
    s = 4'b0001; r = 4'b0001;
    tick();
    chk("clr_set_wins", illegal_mask, 4'b0001);
    clr_illegal = 1'b0; s = '0; r = '0;

    // JK then T
    mode = 2'b10; s = 4'b1111; r = 4'b1111;
    tick();
    chk("jk_q", q, 4'b0011);
    chk("jk_qn", q_n, 4'b1100);
    mode = 2'b11; t = 4'b0001;
    tick();
    chk("t_q", q, 4'b0010);
    chk("t_hist", hist, 16'h05C3);
    chk("t_cnt", trans_count, 8'd4);

    // load beats en
    load = 1'b1; load_val = 4'b1001; t = 4'b1111;
    tick();
    chk("load_q", q, 4'b1001);
    chk("load_changed", changed, 1'b1);
    load = 1'b0; en = 1'b0;
    tick();
    chk("hold_q", q, 4'b1001);
    chk("hold_changed", changed, 1'b0);
    chk("hold_cnt", trans_count, 8'd5);

    // saturation: 300 toggling cycles starting from count 5
    en = 1'b1; mode = 2'b11; t = 4'b0001;
    pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (changed) pulses++;
      if (i == 249) chk("sat_254", trans_count, 8'd254);
      if (i == 250) chk("sat_255", trans_count, 8'd255);
    end
    chk("sat_final", trans_count, 8'd255);
    chk("sat_pulses", pulses, 300);
    chk("sat_q", q, 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
